key_entry_ctrl: RTL and testbench

//  Sequences PS/2 scan-code bytes into a multi-digit decimal entry register.
//  - Tracks make/break/extended prefixes and decodes digit make codes 0-9.
//  - Handles Enter/Escape (and optionally Backspace).
//  - Publishes a committed BCD value with a one-cycle strobe.
//  - Sits between the PS/2 byte receiver and the arithmetic/display logic.

---
 rtl/key_entry_ctrl.sv | 140 ++++++++++++++
 tb/tb_key_entry_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: sequences PS/2 set-2 scan bytes into a BCD digit entry and commits it on Enter.
// Optional Backspace handling is built in when KEY_ENTRY_BKSP_EN is defined.
//
// state   | meaning
// S_MAKE  | next byte is a make code or a prefix
// S_EXT   | E0 seen; the extended make that follows is skipped
// S_BREAK | F0 seen; next byte names the released key and is discarded
module key_entry_ctrl #(
    parameter int NDIGITS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           code_valid,
    input  logic [7:0]                     code,
    output logic [4*NDIGITS-1:0]           entry_bcd,
    output logic [$clog2(NDIGITS+1)-1:0]   digit_cnt,
    output logic [4*NDIGITS-1:0]           value_bcd,
    output logic                           value_valid,
    output logic                           overflow
);

    localparam int BW = 4 * NDIGITS;
    localparam int CW = $clog2(NDIGITS + 1);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_ESC   = 8'h76;
`ifdef KEY_ENTRY_BKSP_EN
    localparam logic [7:0] CODE_BKSP  = 8'h66;
`endif

    typedef enum logic [1:0] {
        S_MAKE  = 2'd0,
        S_EXT   = 2'd1,
        S_BREAK = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     entry_nxt;
    logic [CW-1:0]     cnt_nxt;
    logic [BW-1:0]     value_nxt;
    logic              vv_nxt;
    logic              ov_nxt;

    logic              is_digit;
    logic [3:0]        digit;

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (code)
            8'h45:   digit = 4'd0;
            8'h16:   digit = 4'd1;
            8'h1E:   digit = 4'd2;
            8'h26:   digit = 4'd3;
            8'h25:   digit = 4'd4;
            8'h2E:   digit = 4'd5;
            8'h36:   digit = 4'd6;
            8'h3D:   digit = 4'd7;
            8'h3E:   digit = 4'd8;
            8'h46:   digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_MAKE;
            entry_bcd   <= '0;
            digit_cnt   <= '0;
            value_bcd   <= '0;
            value_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            entry_bcd   <= entry_nxt;
            digit_cnt   <= cnt_nxt;
            value_bcd   <= value_nxt;
            value_valid <= vv_nxt;
            overflow    <= ov_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        entry_nxt = entry_bcd;
        cnt_nxt   = digit_cnt;
        value_nxt = value_bcd;
        vv_nxt    = 1'b0;
        ov_nxt    = 1'b0;
        if (code_valid) begin
            case (state)
                S_MAKE: begin
                    if (code == CODE_BREAK) begin
                        state_nxt = S_BREAK;
                    end else if (code == CODE_EXT) begin
                        state_nxt = S_EXT;
                    end else if (is_digit) begin
                        if (digit_cnt < CW'(NDIGITS)) begin
                            // high nibble is already zero whenever there is room
                            entry_nxt = (entry_bcd << 4) | BW'(digit);
                            cnt_nxt   = digit_cnt + CW'(1);
                        end else begin
                            ov_nxt = 1'b1;
                        end
                    end else if (code == CODE_ENTER) begin
                        if (digit_cnt != '0) begin
                            value_nxt = entry_bcd;
                            vv_nxt    = 1'b1;
                            entry_nxt = '0;
                            cnt_nxt   = '0;
                        end
                    end else if (code == CODE_ESC) begin
                        entry_nxt = '0;
                        cnt_nxt   = '0;
                    end
`ifdef KEY_ENTRY_BKSP_EN
                    else if (code == CODE_BKSP) begin
                        if (digit_cnt != '0) begin
                            entry_nxt = entry_bcd >> 4;
                            cnt_nxt   = digit_cnt - CW'(1);
                        end
                    end
`endif
                end
                S_EXT: begin
                    state_nxt = (code == CODE_BREAK) ? S_BREAK : S_MAKE;
                end
                S_BREAK: begin
                    state_nxt = S_MAKE;
                end
                default: begin
                    state_nxt = S_MAKE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl: directed vector table, reset/backspace sequences,
// then random byte streams against a digit-queue reference model.
module tb_key_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        code_valid = 1'b0;
    logic [7:0]  code = 8'h00;
    logic [15:0] entry_bcd;
    logic [2:0]  digit_cnt;
    logic [15:0] value_bcd;
    logic        value_valid;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    key_entry_ctrl #(.NDIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
        .entry_bcd(entry_bcd), .digit_cnt(digit_cnt), .value_bcd(value_bcd),
        .value_valid(value_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  c;
        logic [15:0] entry;
        int          cnt;
        logic [15:0] value;
        bit          vv;
        bit          ov;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e, input int n,
                           input logic [15:0] v, input bit vv, input bit ov);
        chk({tag, ".entry"}, 32'(entry_bcd), 32'(e));
        chk({tag, ".cnt"}, 32'(digit_cnt), 32'(n));
        chk({tag, ".value"}, 32'(value_bcd), 32'(v));
        chk({tag, ".vv"}, 32'(value_valid), 32'(vv));
        chk({tag, ".ov"}, 32'(overflow), 32'(ov));
    endtask

    // drive one byte for a single cycle; on return outputs reflect that byte
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        code_valid = 1'b1;
        code = c;
        @(negedge clk);
        code_valid = 1'b0;
        code = 8'h00;
    endtask

    task automatic add(input logic [7:0] c, input logic [15:0] e, input int n,
                       input logic [15:0] v, input bit vv, input bit ov);
        vec_t t;
        t.c = c; t.entry = e; t.cnt = n; t.value = v; t.vv = vv; t.ov = ov;
        vecs.push_back(t);
    endtask

    // reference model: digits kept as a queue, prefixes as two flags
    int          m_digits[$];
    bit          m_brk, m_ext;
    logic [15:0] m_value;
    bit          m_vv, m_ov;

    function automatic int dig_of(input logic [7:0] c);
        logic [7:0] tbl [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 10; i++)
            if (tbl[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [15:0] m_entry();
        logic [15:0] e = 16'h0;
        foreach (m_digits[i]) e = e * 16 + 16'(m_digits[i]);
        return e;
    endfunction

    task automatic m_reset();
        m_digits.delete();
        m_brk = 0; m_ext = 0; m_value = 16'h0; m_vv = 0; m_ov = 0;
    endtask

    task automatic m_apply(input logic [7:0] c);
        int d;
        m_vv = 0; m_ov = 0;
        if (m_brk) begin
            m_brk = 0;
        end else if (m_ext) begin
            m_ext = 0;
            if (c == 8'hF0) m_brk = 1;
        end else if (c == 8'hF0) begin
            m_brk = 1;
        end else if (c == 8'hE0) begin
            m_ext = 1;
        end else begin
            d = dig_of(c);
            if (d >= 0) begin
                if (m_digits.size() < 4) m_digits.push_back(d);
                else m_ov = 1;
            end else if (c == 8'h5A) begin
                if (m_digits.size() > 0) begin
                    m_value = m_entry();
                    m_vv = 1;
                    m_digits.delete();
                end
            end else if (c == 8'h76) begin
                m_digits.delete();
            end
`ifdef KEY_ENTRY_BKSP_EN
            else if (c == 8'h66) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
            end
`endif
        end
    endtask

    initial begin
        // 1) 1,2,3 with breaks then Enter
        add(8'h16, 16'h0001, 1, 16'h0000, 0, 0);
        add(8'hF0, 16'h0001, 1, 16'h0000, 0, 0);
        add(8'h16, 16'h0001, 1, 16'h0000, 0, 0);
        add(8'h1E, 16'h0012, 2, 16'h0000, 0, 0);
        add(8'hF0, 16'h0012, 2, 16'h0000, 0, 0);
        add(8'h1E, 16'h0012, 2, 16'h0000, 0, 0);
        add(8'h26, 16'h0123, 3, 16'h0000, 0, 0);
        add(8'hF0, 16'h0123, 3, 16'h0000, 0, 0);
        add(8'h26, 16'h0123, 3, 16'h0000, 0, 0);
        add(8'h5A, 16'h0000, 0, 16'h0123, 1, 0);
        // 2) five digits, overflow on the fifth make only
        add(8'h16, 16'h0001, 1, 16'h0123, 0, 0);
        add(8'hF0, 16'h0001, 1, 16'h0123, 0, 0);
        add(8'h16, 16'h0001, 1, 16'h0123, 0, 0);
        add(8'h1E, 16'h0012, 2, 16'h0123, 0, 0);
        add(8'h26, 16'h0123, 3, 16'h0123, 0, 0);
        add(8'h25, 16'h1234, 4, 16'h0123, 0, 0);
        add(8'h2E, 16'h1234, 4, 16'h0123, 0, 1);
        add(8'hF0, 16'h1234, 4, 16'h0123, 0, 0);
        add(8'h2E, 16'h1234, 4, 16'h0123, 0, 0);
        add(8'h2E, 16'h1234, 4, 16'h0123, 0, 1);
        // 3) Escape, then Enter on empty entry
        add(8'h76, 16'h0000, 0, 16'h0123, 0, 0);
        add(8'h5A, 16'h0000, 0, 16'h0123, 0, 0);
        // 4) extended keys ignored, then digit 0; keypad Enter ignored
        add(8'hE0, 16'h0000, 0, 16'h0123, 0, 0);
        add(8'h70, 16'h0000, 0, 16'h0123, 0, 0);
        add(8'hE0, 16'h0000, 0, 16'h0123, 0, 0);
        add(8'hF0, 16'h0000, 0, 16'h0123, 0, 0);
        add(8'h70, 16'h0000, 0, 16'h0123, 0, 0);
        add(8'h45, 16'h0000, 1, 16'h0123, 0, 0);
        add(8'hE0, 16'h0000, 1, 16'h0123, 0, 0);
        add(8'h5A, 16'h0000, 1, 16'h0123, 0, 0);
        add(8'h1C, 16'h0000, 1, 16'h0123, 0, 0);
        add(8'h45, 16'h0000, 2, 16'h0123, 0, 0);
        add(8'h46, 16'h0009, 3, 16'h0123, 0, 0);
        add(8'h5A, 16'h0000, 0, 16'h0009, 1, 0);

        repeat (2) @(negedge clk);
        chk_all("reset", 16'h0, 0, 16'h0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("post_reset", 16'h0, 0, 16'h0, 0, 0);

        foreach (vecs[i]) begin
            send(vecs[i].c);
            chk_all($sformatf("vec%0d", i), vecs[i].entry, vecs[i].cnt,
                    vecs[i].value, vecs[i].vv, vecs[i].ov);
        end
        @(negedge clk);
        chk("commit_pulse_len", 32'(value_valid), 32'd0);

        // 5) reset mid-entry, including with a break prefix pending
        send(8'h46);
        send(8'h3E);
        chk("rst_pre.entry", 32'(entry_bcd), 32'h0098);
        #2 rst_n = 1'b0;
        #1 chk_all("rst_mid", 16'h0, 0, 16'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h76);
        chk_all("rst_esc", 16'h0, 0, 16'h0, 0, 0);
        send(8'hF0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h45);
        chk_all("rst_prefix", 16'h0, 1, 16'h0, 0, 0);
        send(8'h76);

        // 6) Backspace
        send(8'h3D);
        send(8'h3E);
        send(8'h66);
`ifdef KEY_ENTRY_BKSP_EN
        chk_all("bksp1", 16'h0007, 1, 16'h0, 0, 0);
        send(8'h66);
        chk_all("bksp2", 16'h0000, 0, 16'h0, 0, 0);
        send(8'h66);
        chk_all("bksp3", 16'h0000, 0, 16'h0, 0, 0);
`else
        chk_all("bksp_off", 16'h0078, 2, 16'h0, 0, 0);
`endif
        send(8'h76);

        // random streams against the model
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        for (int n = 0; n < 4000; n++) begin
            int r;
            logic [7:0] pick;
            logic [7:0] dtbl [10];
            @(negedge clk);
            chk_all("rand", m_entry(), m_digits.size(), m_value, m_vv, m_ov);
            if (failures > 20) break;
            dtbl = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
            r = $urandom_range(0, 15);
            pick = 8'h00;
            if (r <= 5)       pick = dtbl[$urandom_range(0, 9)];
            else if (r == 6)  pick = 8'hF0;
            else if (r == 7)  pick = 8'hE0;
            else if (r == 8)  pick = 8'h5A;
            else if (r == 9)  pick = 8'h76;
            else if (r == 10) pick = 8'h66;
            else if (r == 11) pick = 8'($urandom_range(0, 255));
            if (r <= 11) begin
                code_valid = 1'b1;
                code = pick;
                m_apply(pick);
            end else begin
                code_valid = 1'b0;
                code = 8'($urandom_range(0, 255));
                m_vv = 0;
                m_ov = 0;
            end
        end
        code_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
